// File: rtl/mips_harvard_cpu.sv
// mips_harvard_cpu
//   Single-cycle MIPS I integer subset CPU with separate instruction and data
//   ports. Branches and jumps have one delay slot, modelled with a PC / PC_next
//   pair. Execution starts at 0xBFC00000. When control would transfer to
//   address 0, the delay-slot instruction still commits, `active` drops, and
//   all state then stays frozen.
//
//   Optional build macro: MIPS_CPU_MULDIV_EN
//     Adds HI/LO and single-cycle MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
//     Division by zero leaves HI/LO unchanged.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   clk_enable     : 1 = advance, 0 = freeze all state and gate the strobes
//   active         : 1 while executing, 0 once halted
//   register_v0    : live value of GPR $2
//   instr_address  : PC (byte address)
//   instr_readdata : instruction word at instr_address (same cycle)
//   data_address   : load/store byte address (rs + sign_ext(imm))
//   data_write     : store strobe, memory writes on the rising edge
//   data_read      : load strobe
//   data_writedata : store data (rt)
//   data_readdata  : load data, combinational from data_address
module mips_harvard_cpu (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    input  logic        clk_enable,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] data_address,
    output logic        data_write,
    output logic        data_read,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02,
                           OP_JAL   = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05,
                           OP_BLEZ  = 6'h06, OP_BGTZ   = 6'h07, OP_ADDIU = 6'h09,
                           OP_SLTI  = 6'h0a, OP_SLTIU  = 6'h0b, OP_ANDI = 6'h0c,
                           OP_ORI   = 6'h0d, OP_XORI   = 6'h0e, OP_LUI  = 6'h0f,
                           OP_LW    = 6'h23, OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                           FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADDU = 6'h21,
                           FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                           FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2a,
                           FN_SLTU = 6'h2b;
`ifdef MIPS_CPU_MULDIV_EN
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12,
                           FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19,
                           FN_DIV  = 6'h1a, FN_DIVU = 6'h1b;
`endif

    // Architectural state
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        active_q, active_d;
    logic [31:0] regs_q [0:31];
`ifdef MIPS_CPU_MULDIV_EN
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] mul_s_s, mul_u_s;
`endif

    // Instruction fields and operands
    logic [5:0]  op_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, shamt_s;
    logic [15:0] imm_s;
    logic [31:0] rs_val_s, rt_val_s, imm_sext_s, imm_zext_s;
    logic [31:0] pc_plus4_s, pc_plus8_s, br_target_s, j_target_s;
    logic        run_s;

    // Decoded control
    logic        wr_en_s, taken_s, is_lw_s, is_sw_s;
    logic [4:0]  wr_addr_s;
    logic [31:0] wr_data_s, target_s;

    assign op_s        = instr_readdata[31:26];
    assign rs_s        = instr_readdata[25:21];
    assign rt_s        = instr_readdata[20:16];
    assign rd_s        = instr_readdata[15:11];
    assign shamt_s     = instr_readdata[10:6];
    assign funct_s     = instr_readdata[5:0];
    assign imm_s       = instr_readdata[15:0];
    assign rs_val_s    = (rs_s == 5'd0) ? 32'd0 : regs_q[rs_s];
    assign rt_val_s    = (rt_s == 5'd0) ? 32'd0 : regs_q[rt_s];
    assign imm_sext_s  = {{16{imm_s[15]}}, imm_s};
    assign imm_zext_s  = {16'd0, imm_s};
    assign pc_plus4_s  = pc_q + 32'd4;
    assign pc_plus8_s  = pc_q + 32'd8;
    assign br_target_s = pc_plus4_s + {imm_sext_s[29:0], 2'b00};
    assign j_target_s  = {pc_plus4_s[31:28], instr_readdata[25:0], 2'b00};
    // An instruction commits only while running and enabled
    assign run_s       = active_q & clk_enable;
`ifdef MIPS_CPU_MULDIV_EN
    assign mul_s_s = $signed({{32{rs_val_s[31]}}, rs_val_s}) * $signed({{32{rt_val_s[31]}}, rt_val_s});
    assign mul_u_s = {32'd0, rs_val_s} * {32'd0, rt_val_s};
`endif

    // Instruction decode and execute: register write-back, control transfer, memory strobes
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = rd_s;
        wr_data_s = 32'd0;
        taken_s   = 1'b0;
        target_s  = br_target_s;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
`ifdef MIPS_CPU_MULDIV_EN
        hi_d = hi_q;
        lo_d = lo_q;
`endif
        case (op_s)
            OP_RTYPE: begin
                wr_en_s = 1'b1;
                case (funct_s)
                    FN_ADDU: wr_data_s = rs_val_s + rt_val_s;
                    FN_SUBU: wr_data_s = rs_val_s - rt_val_s;
                    FN_AND:  wr_data_s = rs_val_s & rt_val_s;
                    FN_OR:   wr_data_s = rs_val_s | rt_val_s;
                    FN_XOR:  wr_data_s = rs_val_s ^ rt_val_s;
                    FN_NOR:  wr_data_s = ~(rs_val_s | rt_val_s);
                    FN_SLT:  wr_data_s = ($signed(rs_val_s) < $signed(rt_val_s)) ? 32'd1 : 32'd0;
                    FN_SLTU: wr_data_s = (rs_val_s < rt_val_s) ? 32'd1 : 32'd0;
                    FN_SLL:  wr_data_s = rt_val_s << shamt_s;
                    FN_SRL:  wr_data_s = rt_val_s >> shamt_s;
                    FN_SRA:  wr_data_s = 32'($signed(rt_val_s) >>> shamt_s);
                    FN_SLLV: wr_data_s = rt_val_s << rs_val_s[4:0];
                    FN_SRLV: wr_data_s = rt_val_s >> rs_val_s[4:0];
                    FN_SRAV: wr_data_s = 32'($signed(rt_val_s) >>> rs_val_s[4:0]);
                    FN_JR: begin
                        wr_en_s  = 1'b0;
                        taken_s  = 1'b1;
                        target_s = rs_val_s;
                    end
                    FN_JALR: begin
                        taken_s   = 1'b1;
                        target_s  = rs_val_s;
                        wr_data_s = pc_plus8_s;
                    end
`ifdef MIPS_CPU_MULDIV_EN
                    FN_MFHI: wr_data_s = hi_q;
                    FN_MFLO: wr_data_s = lo_q;
                    FN_MTHI: begin wr_en_s = 1'b0; hi_d = rs_val_s; end
                    FN_MTLO: begin wr_en_s = 1'b0; lo_d = rs_val_s; end
                    FN_MULT: begin wr_en_s = 1'b0; {hi_d, lo_d} = mul_s_s; end
                    FN_MULTU: begin wr_en_s = 1'b0; {hi_d, lo_d} = mul_u_s; end
                    FN_DIV: begin
                        wr_en_s = 1'b0;
                        if (rt_val_s != 32'd0) begin
                            lo_d = 32'($signed(rs_val_s) / $signed(rt_val_s));
                            hi_d = 32'($signed(rs_val_s) % $signed(rt_val_s));
                        end else begin
                            lo_d = lo_q;
                            hi_d = hi_q;
                        end
                    end
                    FN_DIVU: begin
                        wr_en_s = 1'b0;
                        if (rt_val_s != 32'd0) begin
                            lo_d = rs_val_s / rt_val_s;
                            hi_d = rs_val_s % rt_val_s;
                        end else begin
                            lo_d = lo_q;
                            hi_d = hi_q;
                        end
                    end
`endif
                    default: wr_en_s = 1'b0;
                endcase
            end
            OP_REGIMM: begin
                // rt selects the condition: 0 = BLTZ, 1 = BGEZ
                case (rt_s)
                    5'd0:    taken_s = rs_val_s[31];
                    5'd1:    taken_s = ~rs_val_s[31];
                    default: taken_s = 1'b0;
                endcase
            end
            OP_J: begin
                taken_s  = 1'b1;
                target_s = j_target_s;
            end
            OP_JAL: begin
                taken_s   = 1'b1;
                target_s  = j_target_s;
                wr_en_s   = 1'b1;
                wr_addr_s = 5'd31;
                wr_data_s = pc_plus8_s;
            end
            OP_BEQ:  taken_s = (rs_val_s == rt_val_s);
            OP_BNE:  taken_s = (rs_val_s != rt_val_s);
            OP_BLEZ: taken_s = rs_val_s[31] | (rs_val_s == 32'd0);
            OP_BGTZ: taken_s = ~rs_val_s[31] & (rs_val_s != 32'd0);
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                wr_en_s   = 1'b1;
                wr_addr_s = rt_s;
                case (op_s)
                    OP_ADDIU: wr_data_s = rs_val_s + imm_sext_s;
                    OP_SLTI:  wr_data_s = ($signed(rs_val_s) < $signed(imm_sext_s)) ? 32'd1 : 32'd0;
                    OP_SLTIU: wr_data_s = (rs_val_s < imm_sext_s) ? 32'd1 : 32'd0;
                    OP_ANDI:  wr_data_s = rs_val_s & imm_zext_s;
                    OP_ORI:   wr_data_s = rs_val_s | imm_zext_s;
                    OP_XORI:  wr_data_s = rs_val_s ^ imm_zext_s;
                    OP_LUI:   wr_data_s = {imm_s, 16'd0};
                    default:  wr_data_s = 32'd0;
                endcase
            end
            OP_LW: begin
                is_lw_s   = 1'b1;
                wr_en_s   = 1'b1;
                wr_addr_s = rt_s;
                wr_data_s = data_readdata;
            end
            OP_SW:   is_sw_s = 1'b1;
            default: wr_en_s = 1'b0;
        endcase
    end

    // Next PC pair and halt detection; the edge that loads PC = 0 clears active
    always_comb begin
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        active_d  = active_q;
        if (run_s) begin
            pc_d      = pc_next_q;
            pc_next_d = taken_s ? target_s : (pc_next_q + 32'd4);
            if (pc_next_q == 32'd0) begin
                active_d = 1'b0;
            end else begin
                active_d = active_q;
            end
        end else begin
            pc_d      = pc_q;
            pc_next_d = pc_next_q;
        end
    end

    // State registers: PC pair, active flag, register file, HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            pc_next_q <= RESET_PC + 32'd4;
            active_q  <= 1'b1;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
`ifdef MIPS_CPU_MULDIV_EN
            hi_q <= 32'd0;
            lo_q <= 32'd0;
`endif
        end else begin
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            active_q  <= active_d;
            if (run_s && wr_en_s && (wr_addr_s != 5'd0)) begin
                regs_q[wr_addr_s] <= wr_data_s;
            end
`ifdef MIPS_CPU_MULDIV_EN
            if (run_s) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
            end
`endif
        end
    end

    assign active         = active_q;
    assign register_v0    = regs_q[2];
    assign instr_address  = pc_q;
    assign data_address   = rs_val_s + imm_sext_s;
    assign data_writedata = rt_val_s;
    assign data_write     = run_s & is_sw_s;
    assign data_read      = run_s & is_lw_s;
endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Directed testbench for mips_harvard_cpu: small programs placed at the reset
// vector, a combinational instruction memory and a clocked-write data memory.
module tb_mips_harvard_cpu;
    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:15];

    int checks = 0;
    int errors = 0;

    mips_harvard_cpu dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .register_v0    (register_v0),
        .clk_enable     (clk_enable),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .data_address   (data_address),
        .data_write     (data_write),
        .data_read      (data_read),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    always #5 clk = ~clk;

    // Instruction memory window at the reset vector; everything else reads NOP
    always_comb begin
        if (instr_address[31:8] == 24'hBFC000) begin
            instr_readdata = imem[instr_address[7:2]];
        end else begin
            instr_readdata = 32'd0;
        end
    end

    assign data_readdata = dmem[data_address[5:2]];

    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (data_write) dmem[data_address[5:2]] <= data_writedata;
    end

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        clk_enable = 1'b1;
        step();
        step();
        chk("rst_pc", instr_address, 32'hBFC00000);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_v0", register_v0, 32'd0);
        reset = 1'b1;
    endtask

    task automatic run_to_halt(input string tag);
        int n;
        n = 0;
        while (active === 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, {31'd0, active}, 32'd0);
    endtask

    localparam logic [31:0] NOP    = 32'd0;
    localparam logic [31:0] JR_ZERO = 32'h0000_0008;

    initial begin
        reset      = 1'b0;
        clk_enable = 1'b1;

        // Test 1: ADDIU $2,$0,5; JR $0; NOP
        clear_imem();
        imem[0] = i_type(6'h09, 5'd0, 5'd2, 16'd5);
        imem[1] = JR_ZERO;
        imem[2] = NOP;
        do_reset();
        chk("t1_pc0", instr_address, 32'hBFC00000);
        step();
        chk("t1_pc1", instr_address, 32'hBFC00004);
        chk("t1_active1", {31'd0, active}, 32'd1);
        chk("t1_v0", register_v0, 32'd5);
        step();
        chk("t1_pc2", instr_address, 32'hBFC00008);
        chk("t1_active2", {31'd0, active}, 32'd1);
        step();
        chk("t1_halted", {31'd0, active}, 32'd0);
        step();
        step();
        chk("t1_v0_after_halt", register_v0, 32'd5);
        chk("t1_pc_frozen", instr_address, 32'h00000000);
        chk("t1_no_write", {31'd0, data_write}, 32'd0);
        chk("t1_no_read", {31'd0, data_read}, 32'd0);

        // Test 2: LUI/ORI build a constant, store it, load it into $2
        clear_imem();
        imem[0] = i_type(6'h0f, 5'd0, 5'd3, 16'h1234);
        imem[1] = i_type(6'h0d, 5'd3, 5'd3, 16'h5678);
        imem[2] = i_type(6'h2b, 5'd0, 5'd3, 16'h0000);
        imem[3] = i_type(6'h23, 5'd0, 5'd2, 16'h0000);
        imem[4] = JR_ZERO;
        imem[5] = NOP;
        do_reset();
        step();
        step();
        chk("t2_sw_write", {31'd0, data_write}, 32'd1);
        chk("t2_sw_addr", data_address, 32'd0);
        chk("t2_sw_data", data_writedata, 32'h12345678);
        chk("t2_sw_noread", {31'd0, data_read}, 32'd0);
        step();
        chk("t2_lw_read", {31'd0, data_read}, 32'd1);
        chk("t2_lw_nowrite", {31'd0, data_write}, 32'd0);
        chk("t2_mem", dmem[0], 32'h12345678);
        run_to_halt("t2_halt");
        chk("t2_v0", register_v0, 32'h12345678);

        // Test 3: taken BEQ, delay slot executes, skipped slot does not
        clear_imem();
        imem[0] = i_type(6'h04, 5'd0, 5'd0, 16'd2);
        imem[1] = i_type(6'h09, 5'd2, 5'd2, 16'd1);
        imem[2] = i_type(6'h09, 5'd2, 5'd2, 16'd1);
        imem[3] = JR_ZERO;
        imem[4] = NOP;
        do_reset();
        step();
        chk("t3_delay_pc", instr_address, 32'hBFC00004);
        step();
        chk("t3_target_pc", instr_address, 32'hBFC0000C);
        run_to_halt("t3_halt");
        chk("t3_v0", register_v0, 32'd1);

        // Test 4: JAL to a subroutine that copies $31 into $2
        clear_imem();
        imem[0] = {6'h03, 26'h3F00004};
        imem[1] = NOP;
        imem[4] = r_type(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
        imem[5] = JR_ZERO;
        imem[6] = NOP;
        do_reset();
        step();
        step();
        chk("t4_sub_pc", instr_address, 32'hBFC00010);
        run_to_halt("t4_halt");
        chk("t4_v0", register_v0, 32'hBFC00008);

        // Test 5: freeze with clk_enable = 0 while the store is current
        clear_imem();
        imem[0] = i_type(6'h0f, 5'd0, 5'd3, 16'h1234);
        imem[1] = i_type(6'h0d, 5'd3, 5'd3, 16'h5678);
        imem[2] = i_type(6'h2b, 5'd0, 5'd3, 16'h0008);
        imem[3] = i_type(6'h23, 5'd0, 5'd2, 16'h0008);
        imem[4] = JR_ZERO;
        imem[5] = NOP;
        do_reset();
        step();
        step();
        clk_enable = 1'b0;
        #1;
        chk("t5_gated_write", {31'd0, data_write}, 32'd0);
        repeat (3) step();
        chk("t5_frozen_pc", instr_address, 32'hBFC00008);
        chk("t5_frozen_v0", register_v0, 32'd0);
        chk("t5_frozen_write", {31'd0, data_write}, 32'd0);
        chk("t5_frozen_read", {31'd0, data_read}, 32'd0);
        chk("t5_mem_untouched", dmem[2], 32'd0);
        clk_enable = 1'b1;
        #1;
        chk("t5_resume_write", {31'd0, data_write}, 32'd1);
        run_to_halt("t5_halt");
        chk("t5_v0", register_v0, 32'h12345678);
        chk("t5_mem", dmem[2], 32'h12345678);

        // Test 6: SRA, SLTU, SUBU chain: -8 >>> 1 = -4; (-8 <u -4) = 1; -4 - 1 = -5
        clear_imem();
        imem[0] = i_type(6'h09, 5'd0, 5'd4, 16'hFFF8);
        imem[1] = r_type(5'd0, 5'd4, 5'd5, 5'd1, 6'h03);
        imem[2] = r_type(5'd4, 5'd5, 5'd6, 5'd0, 6'h2b);
        imem[3] = r_type(5'd5, 5'd6, 5'd2, 5'd0, 6'h23);
        imem[4] = JR_ZERO;
        imem[5] = NOP;
        do_reset();
        run_to_halt("t6_halt");
        chk("t6_v0", register_v0, 32'hFFFFFFFB);

        // Test 7: MULTU 0xFFFFFFFF x 2 then MFHI $2
        clear_imem();
        imem[0] = i_type(6'h09, 5'd0, 5'd4, 16'hFFFF);
        imem[1] = i_type(6'h09, 5'd0, 5'd5, 16'd2);
        imem[2] = r_type(5'd4, 5'd5, 5'd0, 5'd0, 6'h19);
        imem[3] = r_type(5'd0, 5'd0, 5'd2, 5'd0, 6'h10);
        imem[4] = JR_ZERO;
        imem[5] = NOP;
        do_reset();
        run_to_halt("t7_halt");
`ifdef MIPS_CPU_MULDIV_EN
        chk("t7_mfhi", register_v0, 32'd1);
`else
        chk("t7_muldiv_nop", register_v0, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
